// File: rtl/eth_fcs_tx.sv
// rtl/eth_fcs_tx.sv - GMII transmit framer: preamble/SFD, zero padding, CRC-32 FCS, inter-frame gap

// Byte-wise CRC-32 in MSB-first register form; data bits enter LSB first as on the wire.
module crc #(
  parameter logic [31:0] INIT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        if (crc_d[31] ^ d[i]) crc_d = {crc_d[30:0], 1'b0} ^ POLY;
        else                  crc_d = {crc_d[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) crc_q <= INIT;
    else        crc_q <= crc_d;
  end

  assign crc_out = crc_q;
endmodule

module eth_fcs_tx #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int IFG     = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       tx_er,
  output logic       frame_done,
  output logic       frame_err
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]  fi_q, fi_d;
  logic [7:0]  sub_q, sub_d;
  logic        clr_n_q, clr_n_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;

  logic        crc_en;
  logic [7:0]  crc_din;
  logic [31:0] crc_val;
  logic [7:0]  fcs_raw;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  crc #(.INIT(32'hFFFF_FFFF)) u_crc (
    .clk    (clk),
    .clr_n  (rst_n & clr_n_q),
    .en     (crc_en),
    .d      (crc_din),
    .crc_out(crc_val)
  );

  assign cnt_inc = cnt_q + 11'd1;
  assign s_ready = (state_q == S_DATA);

  always_comb begin
    case (fi_q)
      2'd0:    fcs_raw = crc_val[31:24];
      2'd1:    fcs_raw = crc_val[23:16];
      2'd2:    fcs_raw = crc_val[15:8];
      default: fcs_raw = crc_val[7:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fi_d         = fi_q;
    sub_d        = sub_q;
    clr_n_d      = 1'b1;
    tx_data_d    = 8'h00;
    tx_en_d      = 1'b0;
    tx_er_d      = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    crc_en       = 1'b0;
    crc_din      = s_data;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        fi_d  = '0;
        sub_d = '0;
        if (s_valid && clr_n_q) begin
          state_d   = S_PRE;
          tx_data_d = 8'h55;
          tx_en_d   = 1'b1;
        end
      end
      S_PRE: begin
        tx_en_d = 1'b1;
        sub_d   = sub_q + 8'd1;
        if (sub_q == 8'd6) begin
          tx_data_d = 8'hD5;
          sub_d     = '0;
          state_d   = S_DATA;
        end else begin
          tx_data_d = 8'h55;
        end
      end
      S_DATA: begin
        tx_en_d = 1'b1;
        // Underrun and overlength share one abort path: error byte, then straight to the gap.
        if (!s_valid || cnt_q == 11'(MAX_LEN)) begin
          tx_er_d     = 1'b1;
          frame_err_d = 1'b1;
          sub_d       = '0;
          state_d     = S_GAP;
        end else begin
          tx_data_d = s_data;
          crc_en    = 1'b1;
          cnt_d     = cnt_inc;
          if (s_last) state_d = (cnt_inc < 11'(MIN_LEN)) ? S_PAD : S_FCS;
        end
      end
      S_PAD: begin
        tx_en_d = 1'b1;
        crc_en  = 1'b1;
        crc_din = 8'h00;
        cnt_d   = cnt_inc;
        if (cnt_inc == 11'(MIN_LEN)) state_d = S_FCS;
      end
      S_FCS: begin
        tx_en_d   = 1'b1;
        tx_data_d = ~bitrev8(fcs_raw);
        fi_d      = fi_q + 2'd1;
        if (fi_q == 2'd3) begin
          frame_done_d = 1'b1;
          sub_d        = '0;
          state_d      = S_GAP;
        end
      end
      S_GAP: begin
        sub_d = sub_q + 8'd1;
        if (sub_q == 8'(IFG - 1)) begin
          clr_n_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // clr_n_q resets low so the engine also sees one clear cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fi_q         <= '0;
      sub_q        <= '0;
      clr_n_q      <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_en_q      <= 1'b0;
      tx_er_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fi_q         <= fi_d;
      sub_q        <= sub_d;
      clr_n_q      <= clr_n_d;
      tx_data_q    <= tx_data_d;
      tx_en_q      <= tx_en_d;
      tx_er_q      <= tx_er_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_en      = tx_en_q;
  assign tx_er      = tx_er_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_eth_fcs_tx.sv
// tb/tb_eth_fcs_tx.sv - scoreboard bench for eth_fcs_tx
module tb_eth_fcs_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] tx_data;
  logic       tx_en, tx_er, frame_done, frame_err;

  typedef struct packed {
    logic [7:0] data;
    logic       er;
    logic       done;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] pl[$];

  int compared = 0, mismatched = 0;
  int cyc = 0, gap_run = 0, last_gap = 0, en_cnt = 0, ready_cnt = 0;
  int done_cnt = 0, err_cnt = 0, first_en_cyc = 0, valid_cyc = 0;

  eth_fcs_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_er     (tx_er),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_ready) ready_cnt++;
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
      if (tx_en) begin
        en_cnt++;
        if (gap_run > 0) begin
          last_gap     = gap_run;
          first_en_cyc = cyc;
        end
        gap_run = 0;
        if (sb.size() == 0) begin
          check("unexpected_tx_byte", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          check("tx_data", 32'(tx_data), 32'(mon_e.data));
          check("tx_er", 32'(tx_er), 32'(mon_e.er));
          check("frame_done", 32'(frame_done), 32'(mon_e.done));
          check("frame_err", 32'(frame_err), 32'(mon_e.err));
        end
      end else begin
        gap_run++;
        check("idle_tx_er", 32'(tx_er), 32'd0);
        check("idle_pulses", 32'({frame_done, frame_err}), 32'd0);
      end
    end
  end

  task automatic fill(input int len, input bit rnd);
    pl.delete();
    for (int k = 0; k < len; k++) pl.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(k));
  endtask

  task automatic push_expected(input int n, input bit abort);
    logic [7:0]  fr[$];
    logic [31:0] c;
    for (int k = 0; k < 7; k++) sb.push_back(exp_t'{8'h55, 1'b0, 1'b0, 1'b0});
    sb.push_back(exp_t'{8'hD5, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < n; k++) fr.push_back(pl[k]);
    if (abort) begin
      foreach (fr[k]) sb.push_back(exp_t'{fr[k], 1'b0, 1'b0, 1'b0});
      sb.push_back(exp_t'{8'h00, 1'b1, 1'b0, 1'b1});
      return;
    end
    while (fr.size() < 60) fr.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (fr[k]) begin
      sb.push_back(exp_t'{fr[k], 1'b0, 1'b0, 1'b0});
      c = c ^ {24'h0, fr[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) sb.push_back(exp_t'{c[8*k +: 8], 1'b0, (k == 3), 1'b0});
  endtask

  task automatic drive(input int len, input bit last_flag, input int drop_at);
    int i = 0;
    int budget = 0;
    bit acc;
    bit ok;
    valid_cyc = cyc;
    s_valid = 1'b1;
    s_data  = pl[0];
    s_last  = last_flag && (len == 1);
    while (i < len && budget < 5000) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      budget++;
      if (acc) begin
        i++;
        if (i == drop_at) break;
        if (i < len) begin
          s_data = pl[i];
          s_last = last_flag && (i == len - 1);
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
    ok = (i == len) || (i == drop_at);
    check("drive_complete", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    repeat (16) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_er", 32'(tx_er), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_pulses", 32'({frame_done, frame_err}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    fill(60, 1'b0);
    done_cnt = 0;
    push_expected(60, 1'b0);
    drive(60, 1'b1, -1);
    wait_drain("t1");
    check("t1_done_cnt", done_cnt, 1);

    fill(14, 1'b1);
    ready_cnt = 0;
    en_cnt    = 0;
    push_expected(14, 1'b0);
    drive(14, 1'b1, -1);
    wait_drain("t2");
    check("t2_ready_cycles", ready_cnt, 14);
    check("t2_tx_en_cycles", en_cnt, 72);

    fill(60, 1'b1);
    err_cnt  = 0;
    done_cnt = 0;
    push_expected(20, 1'b1);
    drive(60, 1'b1, 20);
    wait_drain("t3");
    check("t3_err_cnt", err_cnt, 1);
    check("t3_done_cnt", done_cnt, 0);

    fill(1515, 1'b1);
    err_cnt = 0;
    push_expected(1514, 1'b1);
    drive(1515, 1'b0, -1);
    wait_drain("t4_over");
    check("t4_err_cnt", err_cnt, 1);
    fill(64, 1'b1);
    push_expected(64, 1'b0);
    drive(64, 1'b1, -1);
    wait_drain("t4_after");

    done_cnt = 0;
    fill(64, 1'b1);
    push_expected(64, 1'b0);
    drive(64, 1'b1, -1);
    fill(64, 1'b1);
    push_expected(64, 1'b0);
    drive(64, 1'b1, -1);
    wait_drain("t5");
    check("t5_gap_cycles", last_gap, 13);
    check("t5_done_cnt", done_cnt, 2);

    fill(64, 1'b1);
    push_expected(64, 1'b0);
    drive(64, 1'b1, -1);
    n = 0;
    while (sb.size() != 1 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("t6_reach_fcs2", 32'(sb.size()), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx_en", 32'(tx_en), 32'd0);
    check("t6_rst_tx_data", 32'(tx_data), 32'd0);
    check("t6_rst_s_ready", 32'(s_ready), 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    fill(30, 1'b0);
    push_expected(30, 1'b0);
    rst_n = 1'b1;
    drive(30, 1'b1, -1);
    wait_drain("t6_next");
    check("t6_start_latency", first_en_cyc - valid_cyc, 2);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
